// File: rtl/crc_codeword_serializer.sv
// rtl/crc_codeword_serializer.sv - packs {msg, crc} into a left-aligned codeword and streams it MSB-first as bytes
module crc_codeword_serializer #(
    parameter int IFG    = 2,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        kind,
    input  logic [19:0]       msg,
    input  logic [9:0]        crc,
    output logic              in_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done,
    output logic              err_kind,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   sr;
    logic [2:0]    remaining;
    logic [GW-1:0] gcnt;
    logic [31:0]   packed_cw;
    logic [2:0]    packed_n;

    // Codeword is MSB-aligned so the first byte on the wire is always sr[31:24].
    always_comb begin
        packed_cw = 32'h0;
        packed_n  = 3'd0;
        case (kind)
            2'd0: begin
                packed_cw = {msg[7:0], crc[3:0], 20'h0};
                packed_n  = 3'd2;
            end
            2'd1: begin
                packed_cw = {msg[15:0], crc[7:0], 8'h0};
                packed_n  = 3'd3;
            end
            2'd3: begin
                packed_cw = {msg[19:0], crc[9:0], 2'b00};
                packed_n  = 3'd4;
            end
            default: begin
                packed_cw = 32'h0;
                packed_n  = 3'd0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (load && kind != 2'd2) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_byte  = sr[31:24];
                out_last  = (remaining == 3'd1);
                if (out_ready && remaining == 3'd1) begin
                    state_nxt = (IFG > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gcnt == GW'(IFG - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= 32'h0;
            remaining  <= 3'd0;
            gcnt       <= '0;
            frame_done <= 1'b0;
            err_kind   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            err_kind   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (kind == 2'd2) begin
                            err_kind <= 1'b1;
                        end else begin
                            sr        <= packed_cw;
                            remaining <= packed_n;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        sr        <= {sr[23:0], 8'h00};
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) begin
                            frame_cnt  <= frame_cnt + FCNT_W'(1);
                            frame_done <= 1'b1;
                            gcnt       <= '0;
                        end
                    end
                end
                GAP: begin
                    gcnt <= gcnt + GW'(1);
                end
                default: begin
                    gcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_codeword_serializer.sv
// tb/tb_crc_codeword_serializer.sv - directed bench with a byte-queue model of the serializer
module tb_crc_codeword_serializer;

    localparam int IFG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  kind = 2'd0;
    logic [19:0] msg = 20'h0;
    logic [9:0]  crc = 10'h0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        frame_done;
    logic        err_kind;
    logic [7:0]  frame_cnt;

    crc_codeword_serializer #(.IFG(IFG), .FCNT_W(8)) dut (
        .clk(clk), .rst(rst), .load(load), .kind(kind), .msg(msg), .crc(crc),
        .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done),
        .err_kind(err_kind), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int       q[$];
    int       log_q[$];
    int       gap_left = 0;
    bit       pend_done = 0;
    bit       pend_err = 0;
    bit       idle;
    logic [7:0] mcnt = 8'h0;
    int       done_cnt = 0;
    int       err_cnt = 0;
    int       last_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Codeword = msg * 2^crc_bits + crc, left-justified into N whole bytes.
    task automatic push_frame(input int k, input int m, input int c);
        int mb, cb, n;
        longint v;
        case (k)
            0: begin mb = 8;  cb = 4;  n = 2; end
            1: begin mb = 16; cb = 8;  n = 3; end
            default: begin mb = 20; cb = 10; n = 4; end
        endcase
        v = ((longint'(m) % (64'd1 << mb)) << cb) + (longint'(c) % (64'd1 << cb));
        v = v << (8 * n - mb - cb);
        for (int i = 0; i < n; i++) q.push_back(int'((v >> (8 * (n - 1 - i))) & 255));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_byte", out_byte, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_err_kind", err_kind, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            q.delete();
            gap_left = 0;
            pend_done = 0;
            pend_err = 0;
            mcnt = 8'h0;
        end else begin
            chk("frame_done", frame_done, pend_done);
            if (pend_done) mcnt = mcnt + 8'd1;
            pend_done = 0;
            chk("err_kind", err_kind, pend_err);
            pend_err = 0;
            if (frame_done) done_cnt++;
            if (err_kind) err_cnt++;
            chk("frame_cnt", frame_cnt, mcnt);
            idle = (q.size() == 0) && (gap_left == 0);
            if (gap_left > 0) gap_left--;
            chk("in_ready", in_ready, idle);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_byte", out_byte, q[0]);
                chk("out_last", out_last, q.size() == 1);
                if (out_ready) begin
                    log_q.push_back(int'(out_byte));
                    if (out_last) last_cnt++;
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        pend_done = 1;
                        gap_left = IFG;
                    end
                end
            end
            if (load && idle) begin
                if (kind == 2'd2) pend_err = 1;
                else push_frame(int'(kind), int'(msg), int'(crc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] k, input logic [19:0] m, input logic [9:0] c);
        kind = k;
        msg = m;
        crc = c;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (in_ready) break;
            step();
        end
        chk("wait_idle_timeout", in_ready, 1);
    endtask

    task automatic check_log(input string name, input int n, input int b0, input int b1,
                             input int b2, input int b3);
        int e[4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        chk({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) chk({name, "_byte"}, log_q[i], e[i]);
        log_q.delete();
    endtask

    int lc0;
    int ec0;
    int low;
    int target;

    initial begin
        step();
        step();
        rst = 1'b1;
        step();

        // T1: upper msg/crc bits must be ignored
        do_load(2'd0, 20'hFFFA5, 10'h3F3);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_latency_byte", out_byte, 8'hA5);
        wait_idle();
        check_log("t1", 2, 8'hA5, 8'h30, 0, 0);
        chk("t1_frame_cnt", frame_cnt, 1);

        // T2: gap length after frame_done
        do_load(2'd1, 20'h01234, 10'h0AB);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (frame_done) break;
        end
        chk("t2_done_seen", frame_done, 1);
        low = 0;
        while (!in_ready && low < 20) begin
            low++;
            @(negedge clk);
            #1;
        end
        chk("t2_gap_cycles", low, 2);
        step();
        wait_idle();
        check_log("t2", 3, 8'h12, 8'h34, 8'hAB, 0);

        // T3
        lc0 = last_cnt;
        do_load(2'd3, 20'hABCDE, 10'h3FF);
        wait_idle();
        check_log("t3", 4, 8'hAB, 8'hCD, 8'hEF, 8'hFC);
        chk("t3_last_once", last_cnt - lc0, 1);

        // T4: stall on byte 2 while hammering load
        do_load(2'd3, 20'hABCDE, 10'h3FF);
        step();
        out_ready = 1'b0;
        kind = 2'd1;
        msg = 20'h0BEEF;
        load = 1'b1;
        step();
        chk("t4_hold_byte", out_byte, 8'hCD);
        step();
        step();
        chk("t4_hold_byte2", out_byte, 8'hCD);
        out_ready = 1'b1;
        load = 1'b0;
        wait_idle();
        check_log("t4", 4, 8'hAB, 8'hCD, 8'hEF, 8'hFC);
        chk("t4_frame_cnt", frame_cnt, 4);

        // T5: illegal kind
        ec0 = err_cnt;
        do_load(2'd2, 20'h12345, 10'h155);
        chk("t5_in_ready", in_ready, 1);
        step();
        step();
        chk("t5_err_pulses", err_cnt - ec0, 1);
        chk("t5_no_bytes", log_q.size(), 0);
        chk("t5_frame_cnt", frame_cnt, 4);

        // T6: reset mid-frame
        do_load(2'd3, 20'hABCDE, 10'h3FF);
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check_log("t6_pre", 1, 8'hAB, 0, 0, 0);
        do_load(2'd1, 20'h0BEEF, 10'h05A);
        wait_idle();
        check_log("t6", 3, 8'hBE, 8'hEF, 8'h5A, 0);
        chk("t6_frame_cnt", frame_cnt, 1);

        // frame_cnt wrap with back-to-back kind0 frames
        target = done_cnt + 254;
        kind = 2'd0;
        msg = 20'h0003C;
        crc = 10'h009;
        load = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            step();
            if (done_cnt >= target) break;
        end
        load = 1'b0;
        wait_idle();
        chk("wrap_pre", frame_cnt, 8'hFF);
        log_q.delete();
        do_load(2'd0, 20'h00081, 10'h00E);
        wait_idle();
        chk("wrap_zero", frame_cnt, 8'h00);
        check_log("wrap", 2, 8'h81, 8'hE0, 0, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
